// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command
// bytes and the odd-parity helper. Also intended for keyboard_decoder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE,
    ERROR
  } ps2_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;

  // Byte the keyboard returns after accepting a command (receiver side).
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 uses odd parity: data plus parity bit carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Input conditioning for one PS/2 line: 2-FF synchroniser, optional
// 4-sample stability filter (PS2_TX_GLITCH_FILTER_EN) and a falling-edge
// strobe. Lines idle high, so every stage resets to 1.
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync_ff;
  logic       prev;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync_ff <= 2'b11;
    else         sync_ff <= {sync_ff[0], pin};
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [2:0] hist;
  logic       filt;

  // Output follows the synchronised line only after 4 equal consecutive samples.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hist <= 3'b111;
      filt <= 1'b1;
    end else begin
      hist <= {hist[1:0], sync_ff[1]};
      if (hist == {3{sync_ff[1]}}) filt <= sync_ff[1];
    end
  end

  assign level = filt;
`else
  assign level = sync_ff[1];
`endif

  // Previous level, used to detect a high-to-low transition.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) prev <= 1'b1;
    else         prev <= level;
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, device-clocked).
// Drives open-drain enables only; the top level builds line = oe ? 0 : z.
// Optional input glitch filter: define PS2_TX_GLITCH_FILTER_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, tx_ready high, waiting for tx_valid
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQ       | clock and data low for one cycle (start bit)
// SEND      | clock released, data/parity/stop shifted on each device fall
// ACK       | stop presented, next device fall samples the ACK bit
// WAIT_IDLE | waiting for both lines high again
// DONE      | one-cycle tx_done pulse
// ERROR     | one-cycle tx_error pulse (NACK or timeout), lines released
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES   = 6000,
  parameter int unsigned TIMEOUT_CYCLES   = 1000000,
  parameter int unsigned IDLE_WAIT_CYCLES = 2500000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W  = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int IDLE_W = $clog2(IDLE_WAIT_CYCLES) + 1;

  ps2_state_e        state;
  logic [9:0]        shreg;
  logic [3:0]        bit_idx;
  logic [INH_W-1:0]  inh_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic clk_level;
  logic clk_fall;
  logic dat_level;

  ps2_line_sync u_clk_sync (
    .clock  (clock),
    .resetn (resetn),
    .pin    (ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clock  (clock),
    .resetn (resetn),
    .pin    (ps2_dat_in),
    .level  (dat_level),
    .fall   ()
  );

  // Transmit sequencer; all outputs are registered alongside the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      inh_cnt    <= '0;
      tmo_cnt    <= '0;
      idle_cnt   <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= {1'b1, odd_parity(tx_data), tx_data};
            bit_idx    <= '0;
            inh_cnt    <= INH_W'(INHIBIT_CYCLES - 1);
            state      <= INHIBIT;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        INHIBIT: begin
          if (inh_cnt == '0) begin
            state      <= REQ;
            ps2_dat_oe <= 1'b1;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        REQ: begin
          state      <= SEND;
          ps2_clk_oe <= 1'b0;
          tmo_cnt    <= TMO_W'(TIMEOUT_CYCLES - 1);
        end
        SEND: begin
          // Timeout is checked first so it wins over a coincident clock fall.
          if (tmo_cnt == '0) begin
            state      <= ERROR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (clk_fall) begin
              ps2_dat_oe <= ~shreg[0];
              shreg      <= {1'b0, shreg[9:1]};
              bit_idx    <= bit_idx + 1'b1;
              if (bit_idx == 4'd9) state <= ACK;
            end
          end
        end
        ACK: begin
          if (tmo_cnt == '0) begin
            state      <= ERROR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
            if (clk_fall) begin
              if (!dat_level) begin
                state    <= WAIT_IDLE;
                idle_cnt <= IDLE_W'(IDLE_WAIT_CYCLES - 1);
              end else begin
                state      <= ERROR;
                tx_error   <= 1'b1;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_level && dat_level) begin
            state   <= DONE;
            tx_done <= 1'b1;
          end else if (idle_cnt == '0) begin
            state      <= ERROR;
            tx_error   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        DONE, ERROR: begin
          state      <= IDLE;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard model clocks frames out of
// the host and records the bits it sees on its rising clock edges.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 200;
  localparam int TMO  = 1500;
  localparam int IDW  = 300;
  localparam int HALF = 25;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES   (INH),
    .TIMEOUT_CYCLES   (TMO),
    .IDLE_WAIT_CYCLES (IDW)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int viol     = 0;

  // Pulse counting and per-cycle rules that must always hold.
  always @(negedge clock) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
    if (resetn) begin
      if (tx_done && tx_error) viol++;
      if (busy == tx_ready) viol++;
      if (tx_ready && (ps2_clk_oe || ps2_dat_oe)) viol++;
      if ((tx_done || tx_error) && (ps2_clk_oe || ps2_dat_oe)) viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame: data LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // Keyboard model: waits for the request-to-send, then generates nclk clocks.
  task automatic device_frame(input bit ack, input int nclk, output logic [9:0] got,
                              output bit started);
    int n;
    got = '0;
    started = 1'b0;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < INH + 100) begin
      @(negedge clock);
      n++;
    end
    if (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) begin
      started = 1'b1;
      for (int i = 0; i < nclk; i++) begin
        if (i == 10 && ack) dev_dat_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        if (i < 10) got[i] = dat_line;
        dev_dat_low = 1'b0;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, output logic [9:0] got,
                          output int dd, output int de);
    int  d0, e0, n;
    bit  started;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx_ready && n < 20);
    tx_valid = 1'b0;
    check("accept", 32'(tx_ready), 32'd0);
    device_frame(ack, 11, got, started);
    check("request_seen", 32'(started), 32'd1);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_bits;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] got;
  int         dd, de, n, d0, e0;
  bit         started;
  logic [7:0] rd;
  bit         rack;

  initial begin
    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
    vecs[1] = '{8'hFF, 1'b0, 10'h3FF, 0, 1};
    vecs[2] = '{8'hF4, 1'b1, 10'h2F4, 1, 0};
    vecs[3] = '{8'hFA, 1'b1, 10'h3FA, 1, 0};
    vecs[4] = '{8'h00, 1'b0, 10'h300, 0, 1};

    repeat (5) @(negedge clock);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      run_xfer(vecs[v].data, vecs[v].ack, got, dd, de);
      check($sformatf("vec%0d_bits", v), 32'(got), 32'(vecs[v].exp_bits));
      check($sformatf("vec%0d_done", v), 32'(dd), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v), 32'(de), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_ready", v), 32'(tx_ready), 32'd1);
    end

    // Randomised frames against the reference model.
    for (int r = 0; r < 6; r++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_xfer(rd, rack, got, dd, de);
      check($sformatf("rand%0d_bits_%02h", r, rd), 32'(got), 32'(model_frame(rd)));
      check($sformatf("rand%0d_done", r), 32'(dd), rack ? 32'd1 : 32'd0);
      check($sformatf("rand%0d_err", r), 32'(de), rack ? 32'd0 : 32'd1);
    end

    // Inhibit timing and request ordering, byte 0x01.
    @(negedge clock);
    tx_data = 8'h01;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 20) begin
      @(negedge clock);
      n++;
    end
    check("inhibit_len", 32'(n), 32'(INH));
    n = 0;
    while (ps2_clk_oe && ps2_dat_oe && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("req_len", 32'(n), 32'd1);
    check("send_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
    d0 = done_cnt;
    device_frame(1'b1, 11, got, started);
    repeat (10) @(negedge clock);
    check("x01_bits", 32'(got), 32'(model_frame(8'h01)));
    check("x01_parity", 32'(got[8]), 32'd0);
    check("x01_done", 32'(done_cnt - d0), 32'd1);

    // Device never clocks: timeout measured from SEND entry.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    tx_data = CMD_RESET;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < INH + 50) begin
      @(negedge clock);
      n++;
    end
    check("tmo_send_entry", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
    n = 0;
    while (!tx_error && n < TMO + 20) begin
      @(negedge clock);
      n++;
    end
    check("tmo_len", 32'(n), 32'(TMO));
    check("tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    @(negedge clock);
    check("tmo_ready", 32'(tx_ready), 32'd1);
    check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    check("tmo_one_err", 32'(err_cnt - e0), 32'd1);

    // Asynchronous reset after the 4th data bit, then a clean 0xF4.
    @(negedge clock);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    device_frame(1'b0, 4, got, started);
    check("mid_bits", 32'(got[3:0]), 32'd0);
    check("mid_dat_oe", 32'(ps2_dat_oe), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("async_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("async_ready", 32'(tx_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    run_xfer(CMD_ENABLE, 1'b1, got, dd, de);
    check("post_rst_bits", 32'(got), 32'(model_frame(CMD_ENABLE)));
    check("post_rst_done", 32'(dd), 32'd1);
    check("post_rst_err", 32'(de), 32'd0);

    // tx_valid held high, tx_data changed mid-frame.
    @(negedge clock);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tx_ready && n < 20);
    fork
      device_frame(1'b1, 11, got, started);
      begin
        repeat (INH + 100) @(negedge clock);
        tx_data = 8'h3C;
      end
    join
    check("hold_bits", 32'(got), 32'(model_frame(8'hA5)));
    n = 0;
    while (!tx_done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("hold_done", 32'(tx_done), 32'd1);
    @(negedge clock);
    check("hold_idle_gap", 32'(tx_ready), 32'd1);
    @(negedge clock);
    check("hold_restart", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    d0 = done_cnt;
    device_frame(1'b1, 11, got, started);
    repeat (10) @(negedge clock);
    check("second_bits", 32'(got), 32'(model_frame(8'h3C)));
    check("second_done", 32'(done_cnt - d0), 32'd1);

    check("invariant_violations", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
